// File: rtl/sd_sector_responder_if.sv
// Sector-buffer, mount and backing-store signal bundle for sd_sector_responder.
// Latency: none, pure wiring.
// Backpressure: none; the sd_rd/sd_wr request level is the only flow control.
//
// Port summary:
//   sd_*      : core sector-buffer handshake (request, ack, buffer RAM port)
//   mount_req / img_mounted / img_size : image announcement
//   mem_*     : word-wide backing store, one-cycle read latency
//   oob       : sticky out-of-range LBA flag
// master = the responder, slave = the core plus the backing store.
interface sd_sector_responder_if #(
    parameter int LBA_BITS = 7
);
    logic [31:0]           sd_lba;
    logic                  sd_rd;
    logic                  sd_wr;
    logic                  sd_ack;
    logic [7:0]            sd_buff_addr;
    logic [15:0]           sd_buff_dout;
    logic                  sd_buff_wr;
    logic [15:0]           sd_buff_din;
    logic                  mount_req;
    logic                  img_mounted;
    logic [63:0]           img_size;
    logic [LBA_BITS+7:0]   mem_addr;
    logic                  mem_rd;
    logic [15:0]           mem_dout;
    logic                  mem_wr;
    logic [15:0]           mem_din;
    logic                  oob;

    modport master (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, mount_req, mem_dout,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               img_mounted, img_size, mem_addr, mem_rd, mem_wr, mem_din, oob
    );

    modport slave (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, mount_req, mem_dout,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               img_mounted, img_size, mem_addr, mem_rd, mem_wr, mem_din, oob
    );
endinterface

// File: rtl/sd_sector_responder.sv
// Host-side sector responder: streams 512-byte sectors between a backing store and the core buffer.
// Latency: sd_ack rises 1+ACK_DELAY cycles after the request is sampled; 256 words, one per cycle.
// Backpressure: none; once sd_ack is high the transfer runs to completion, request changes ignored.
//
// Ports:
//   clk_sys : system clock
//   RESET_N : asynchronous active-low reset
//   bus     : sd_sector_responder_if.master (sector handshake, mount, backing store, oob)
module sd_sector_responder #(
    parameter int LBA_BITS    = 7,
    parameter int IMG_SECTORS = 128,
    parameter int ACK_DELAY   = 4
) (
    input  logic                         clk_sys,
    input  logic                         RESET_N,
    sd_sector_responder_if.master        bus
);
    localparam logic [7:0]  DLY     = 8'(ACK_DELAY);
    localparam logic [31:0] IMG_LIM = 32'(IMG_SECTORS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_XFER_RD,
        S_XFER_WR,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [7:0]            r_dly;
    logic [8:0]            r_cnt;        // word being issued; bit 8 marks the drain cycle
    logic                  r_pend;       // a word issued last cycle completes this cycle
    logic [7:0]            r_buff_addr;  // word index of the completing beat, held afterwards
    logic [LBA_BITS-1:0]   r_lba;
    logic                  r_dir_rd;
    logic                  r_is_oob;     // current transfer is out of range
    logic                  r_oob;        // sticky
    logic                  r_mounted;

    logic                  w_req;
    logic                  w_in_xfer;
    logic                  w_issue;
    logic                  w_rd_issue;
    logic                  w_wr_present;
    logic                  w_buff_wr;
    logic                  w_mem_rd;
    logic                  w_mem_wr;
    logic                  w_lba_oob;

    assign w_req        = bus.sd_rd | bus.sd_wr;
    assign w_lba_oob    = (bus.sd_lba >= IMG_LIM);
    assign w_in_xfer    = (r_state == S_XFER_RD) || (r_state == S_XFER_WR);
    assign w_issue      = w_in_xfer && !r_cnt[8];
    assign w_rd_issue   = (r_state == S_XFER_RD) && !r_cnt[8];
    assign w_wr_present = (r_state == S_XFER_WR) && !r_cnt[8];

    assign w_buff_wr = r_pend && (r_state == S_XFER_RD);
    assign w_mem_rd  = w_rd_issue && !r_is_oob;
    assign w_mem_wr  = r_pend && (r_state == S_XFER_WR) && !r_is_oob;

    // State register
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    // With no delay configured the ack must rise on the very next cycle.
                    if (DLY == 8'd0) begin
                        w_next = bus.sd_rd ? S_XFER_RD : S_XFER_WR;
                    end else begin
                        w_next = S_DELAY;
                    end
                end
            end
            S_DELAY: begin
                if (r_dly == DLY) begin
                    w_next = r_dir_rd ? S_XFER_RD : S_XFER_WR;
                end
            end
            S_XFER_RD, S_XFER_WR: begin
                if (r_cnt[8]) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dly       <= 8'd0;
            r_cnt       <= 9'd0;
            r_pend      <= 1'b0;
            r_buff_addr <= 8'd0;
            r_lba       <= '0;
            r_dir_rd    <= 1'b0;
            r_is_oob    <= 1'b0;
            r_oob       <= 1'b0;
            r_mounted   <= 1'b0;
        end else begin
            r_mounted <= bus.mount_req;
            r_pend    <= w_issue;

            if (r_state == S_IDLE && w_req) begin
                r_lba    <= bus.sd_lba[LBA_BITS-1:0];
                r_dir_rd <= bus.sd_rd;
                r_is_oob <= w_lba_oob;
                r_dly    <= 8'd1;
                if (w_lba_oob) begin
                    r_oob <= 1'b1;
                end
            end else if (r_state == S_DELAY) begin
                r_dly <= r_dly + 8'd1;
            end

            if (w_issue) begin
                r_cnt       <= r_cnt + 9'd1;
                r_buff_addr <= r_cnt[7:0];
            end else if (!w_in_xfer) begin
                r_cnt <= 9'd0;
            end
        end
    end

    // Writes present the word index directly so the buffer RAM data arrives
    // one cycle later, in step with the mem_wr of that word.
    assign bus.sd_ack       = w_in_xfer;
    assign bus.sd_buff_addr = w_wr_present ? r_cnt[7:0] : r_buff_addr;
    assign bus.sd_buff_wr   = w_buff_wr;
    assign bus.sd_buff_dout = (w_buff_wr && !r_is_oob) ? bus.mem_dout : 16'd0;
    assign bus.mem_rd       = w_mem_rd;
    assign bus.mem_wr       = w_mem_wr;
    assign bus.mem_addr     = w_mem_rd ? {r_lba, r_cnt[7:0]} :
                              w_mem_wr ? {r_lba, r_buff_addr} : '0;
    assign bus.mem_din      = w_mem_wr ? bus.sd_buff_din : 16'd0;
    assign bus.oob          = r_oob;
    assign bus.img_mounted  = r_mounted;
    assign bus.img_size     = 64'(IMG_SECTORS) * 64'd512;
endmodule

// File: tb/tb_sd_sector_responder.sv
// Scoreboard bench for sd_sector_responder: directed transfers push expected
// buffer/backing-store beats into a queue, a negedge monitor pops and compares.
module tb_sd_sector_responder;
    localparam int AD = 4;
    localparam int LB = 7;

    logic clk_sys = 1'b0;
    logic RESET_N = 1'b0;
    always #5 clk_sys = ~clk_sys;

    sd_sector_responder_if #(.LBA_BITS(LB)) bus ();

    sd_sector_responder #(
        .LBA_BITS(LB),
        .IMG_SECTORS(128),
        .ACK_DELAY(AD)
    ) dut (
        .clk_sys(clk_sys),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    typedef struct packed {
        logic        is_mem;
        logic [14:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t  exp_q[$];
    int   vecs = 0;
    int   miscompares = 0;
    int   stray = 0;
    int   rd_cnt = 0;
    bit   wrote127 = 0;
    logic [15:0] bmem [0:32767];

    // Backing store (one-cycle read latency) and core buffer returning ~addr.
    always @(posedge clk_sys) begin
        if (bus.mem_rd) bus.mem_dout <= bmem[bus.mem_addr];
        if (bus.mem_wr) bmem[bus.mem_addr] <= bus.mem_din;
        bus.sd_buff_din <= ~{8'h00, bus.sd_buff_addr};
    end

    function automatic logic [15:0] pat(input int a);
        return 16'(a * 3 + 32'h0123);
    endfunction

    function automatic logic [15:0] exp_rd(input int lba, input int w);
        if (lba == 3) return 16'(16'h3000 + w);
        if (lba == 127 && wrote127) return 16'(16'hFFFF - w);
        return pat(lba * 256 + w);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input logic is_mem, input logic [14:0] addr, input logic [15:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            vecs++;
            miscompares++;
            $display("FAIL unexpected_strobe: got mem=%0d addr=%0h data=%0h, expected none", is_mem, addr, data);
        end else begin
            e = exp_q.pop_front();
            check(is_mem ? "mem_wr_beat" : "buff_wr_beat",
                  64'({is_mem, addr, data}), 64'({e.is_mem, e.addr, e.data}));
        end
    endtask

    always @(negedge clk_sys) begin
        if (RESET_N) begin
            if (bus.sd_buff_wr) mon(1'b0, {7'd0, bus.sd_buff_addr}, bus.sd_buff_dout);
            if (bus.mem_wr)     mon(1'b1, bus.mem_addr, bus.mem_din);
            if (!bus.sd_ack && (bus.sd_buff_wr || bus.mem_wr || bus.mem_rd)) stray++;
            if (bus.mem_rd) rd_cnt++;
        end
    end

    task automatic push_rd(input int lba, input bit zero, input int nwords);
        for (int w = 0; w < nwords; w++)
            exp_q.push_back('{1'b0, 15'(w), zero ? 16'd0 : exp_rd(lba, w)});
    endtask

    task automatic push_wr(input int lba);
        for (int w = 0; w < 256; w++)
            exp_q.push_back('{1'b1, 15'(lba * 256 + w), 16'(16'hFFFF - w)});
    endtask

    // Raise a request at the current negedge, drop it on the ack rise, and
    // return on the first negedge where ack has fallen again.
    task automatic xfer(input bit rd, input bit wr, input logic [31:0] lba,
                        input int exp_first, input int exp_stb, input string tag);
        int first_ack = 0;
        int ack_cnt = 0;
        int first_stb = 0;
        int stb_cnt = 0;
        bit done = 0;
        bus.sd_rd  = rd;
        bus.sd_wr  = wr;
        bus.sd_lba = lba;
        for (int i = 1; i <= 700 && !done; i++) begin
            @(negedge clk_sys);
            if (bus.sd_ack) begin
                if (first_ack == 0) begin
                    first_ack  = i;
                    bus.sd_rd  = 1'b0;
                    bus.sd_wr  = 1'b0;
                    bus.sd_lba = 32'hDEAD_BEEF;
                end
                ack_cnt++;
            end else if (first_ack != 0) begin
                done = 1;
            end
            if (bus.sd_buff_wr || bus.mem_wr) begin
                if (first_stb == 0) first_stb = i;
                stb_cnt++;
            end
        end
        bus.sd_rd = 1'b0;
        bus.sd_wr = 1'b0;
        check({tag, "_ack_rise"}, 64'(first_ack), 64'(exp_first));
        check({tag, "_ack_len"}, 64'(ack_cnt), 64'd257);
        check({tag, "_strobes"}, 64'(stb_cnt), 64'(exp_stb));
        if (exp_stb > 0) check({tag, "_first_strobe"}, 64'(first_stb), 64'(exp_first + 1));
    endtask

    initial begin
        int rd0;
        bit found;
        bus.sd_lba    = 32'd0;
        bus.sd_rd     = 1'b0;
        bus.sd_wr     = 1'b0;
        bus.mount_req = 1'b0;
        for (int a = 0; a < 32768; a++) bmem[a] = pat(a);
        for (int w = 0; w < 256; w++) bmem[3 * 256 + w] = 16'(16'h3000 + w);

        // Reset state
        #2;
        check("rst_ack",      64'(bus.sd_ack), 64'd0);
        check("rst_buff_wr",  64'(bus.sd_buff_wr), 64'd0);
        check("rst_buff_addr",64'(bus.sd_buff_addr), 64'd0);
        check("rst_buff_dout",64'(bus.sd_buff_dout), 64'd0);
        check("rst_mem_rd",   64'(bus.mem_rd), 64'd0);
        check("rst_mem_wr",   64'(bus.mem_wr), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_din",  64'(bus.mem_din), 64'd0);
        check("rst_oob",      64'(bus.oob), 64'd0);
        check("rst_mounted",  64'(bus.img_mounted), 64'd0);
        check("rst_img_size", bus.img_size, 64'd65536);
        repeat (3) @(negedge clk_sys);
        RESET_N = 1'b1;
        repeat (2) @(negedge clk_sys);

        // Read sector 3
        push_rd(3, 0, 256);
        xfer(1'b1, 1'b0, 32'd3, 1 + AD, 256, "read3");
        check("read3_addr_hold", 64'(bus.sd_buff_addr), 64'd255);
        repeat (2) @(negedge clk_sys);

        // Write sector 127 from the buffer model (~addr)
        push_wr(127);
        xfer(1'b0, 1'b1, 32'd127, 1 + AD, 256, "write127");
        wrote127 = 1;
        repeat (2) @(negedge clk_sys);

        // Back-to-back sequencer over the whole image
        for (int l = 0; l < 128; l++) begin
            push_rd(l, 0, 256);
            xfer(1'b1, 1'b0, 32'(l), (l == 0) ? 1 + AD : 2 + AD, 256, "seq");
        end
        check("seq_queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk_sys);

        // Both requests: read wins
        push_rd(3, 0, 256);
        xfer(1'b1, 1'b1, 32'd3, 1 + AD, 256, "both");
        repeat (2) @(negedge clk_sys);

        // Out of range
        check("oob_before", 64'(bus.oob), 64'd0);
        rd0 = rd_cnt;
        push_rd(200, 1, 256);
        xfer(1'b1, 1'b0, 32'd200, 1 + AD, 256, "oob_rd");
        check("oob_rd_no_mem_rd", 64'(rd_cnt - rd0), 64'd0);
        check("oob_set", 64'(bus.oob), 64'd1);
        repeat (2) @(negedge clk_sys);
        xfer(1'b0, 1'b1, 32'h8000_0001, 1 + AD, 0, "oob_wr");
        check("oob_sticky", 64'(bus.oob), 64'd1);
        repeat (2) @(negedge clk_sys);

        // Reset at word 100 of a read
        push_rd(5, 0, 101);
        bus.sd_rd  = 1'b1;
        bus.sd_lba = 32'd5;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk_sys);
            if (bus.sd_ack) bus.sd_rd = 1'b0;
            if (bus.sd_buff_wr && bus.sd_buff_addr == 8'd100) found = 1;
        end
        bus.sd_rd = 1'b0;
        check("rst_mid_reached_w100", 64'(found), 64'd1);
        #1 RESET_N = 1'b0;
        #1;
        check("rst_mid_ack",     64'(bus.sd_ack), 64'd0);
        check("rst_mid_buff_wr", 64'(bus.sd_buff_wr), 64'd0);
        check("rst_mid_mem_rd",  64'(bus.mem_rd), 64'd0);
        check("rst_mid_oob_clr", 64'(bus.oob), 64'd0);
        check("rst_mid_queue",   64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk_sys);
        RESET_N = 1'b1;
        repeat (5) @(negedge clk_sys);
        check("post_rst_ack", 64'(bus.sd_ack), 64'd0);

        // Mount pulse
        check("mount_idle", 64'(bus.img_mounted), 64'd0);
        bus.mount_req = 1'b1;
        @(negedge clk_sys);
        bus.mount_req = 1'b0;
        check("mount_pulse", 64'(bus.img_mounted), 64'd1);
        @(negedge clk_sys);
        check("mount_one_cycle", 64'(bus.img_mounted), 64'd0);
        check("img_size", bus.img_size, 64'd65536);

        // Fresh read after reset starts from IDLE with normal timing
        push_rd(1, 0, 256);
        xfer(1'b1, 1'b0, 32'd1, 1 + AD, 256, "post_rst_read");
        repeat (3) @(negedge clk_sys);

        check("no_strobe_outside_ack", 64'(stray), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
